oclib_reset_sequencer: RTL and testbench

- Parametrised reset conditioner and distributor; successor to the single-output sync+pipeline reset block.
- Takes one async reset plus an optional synchronous soft-reset request.
- Drives NumOutputs reset domains that assert together and release in index order, one every StepCycles, after a minimum stretch.
- Sits at chip/subsystem top, feeding reset trees of dependent blocks (e.g. PLL-side logic first, fabric last).

---
 rtl/oclib_pkg.sv | 15 +
 rtl/oclib_reset_pipe.sv | 37 +++
 rtl/oclib_reset_sequencer.sv | 154 +++++++++++++++
 tb/tb_oclib_reset_sequencer.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/oclib_pkg.sv
// Shared oclib types and helpers.
package oclib_pkg;

  typedef enum logic [1:0] {
    ASSERT,
    STRETCH,
    RELEASE,
    DONE
  } oclib_reset_seq_state_e;

  function automatic int unsigned oclib_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/oclib_reset_pipe.sv
// Length-stage reset pipeline, async reset to ResetValue; a wire when Length is 0.
module oclib_reset_pipe #(
  parameter int unsigned Length     = 1,
  parameter bit          ResetValue = 1'b0
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  if (Length == 0) begin : g_bypass
    logic unused_clk_rst;
    assign unused_clk_rst = clock_i ^ reset_i;
    assign q_o            = d_i;
  end else begin : g_stages
    logic [Length-1:0] stage_q, stage_d;

    always_comb begin
      stage_d[0] = d_i;
      for (int i = 1; i < int'(Length); i++) begin
        stage_d[i] = stage_q[i-1];
      end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
      if (reset_i) begin
        stage_q <= {Length{ResetValue}};
      end else begin
        stage_q <= stage_d;
      end
    end

    assign q_o = stage_q[Length-1];
  end

endmodule

// File: rtl/oclib_reset_sequencer.sv
// Reset conditioner: synchronized release, stretch, then index-ordered release of out[].
// Optional OCLIB_RESET_SEQUENCER_HOLD_EN adds a 'hold' input that freezes sequencing.
module oclib_reset_sequencer
  import oclib_pkg::*;
#(
  parameter int unsigned NumOutputs    = 4,
  parameter int unsigned SyncCycles    = 3,
  parameter int unsigned StretchCycles = 16,
  parameter int unsigned StepCycles    = 8,
  parameter int unsigned ResetPipeline = 0,
  parameter int unsigned CounterWidth  = $clog2(oclib_max(StretchCycles, StepCycles)) + 1
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  softReset,
`ifdef OCLIB_RESET_SEQUENCER_HOLD_EN
  input  logic                  hold,
`endif
  output logic [NumOutputs-1:0] out,
  output logic                  done
);

  localparam int unsigned IdxWidth = (NumOutputs > 1) ? $clog2(NumOutputs) : 1;

  oclib_reset_seq_state_e  state_q, state_d;
  logic [CounterWidth-1:0] cnt_q, cnt_d;
  logic [IdxWidth-1:0]     idx_q, idx_d;
  logic [NumOutputs-1:0]   out_q, out_d;
  logic                    done_q, done_d;
  logic                    reset_sync;
  logic                    hold_active;

`ifdef OCLIB_RESET_SEQUENCER_HOLD_EN
  assign hold_active = hold;
`else
  assign hold_active = 1'b0;
`endif

  // Async-set chain: assertion is immediate, release lands on the SyncCycles-th edge.
  oclib_reset_pipe #(
    .Length    (SyncCycles),
    .ResetValue(1'b1)
  ) u_sync (
    .clock_i(clock),
    .reset_i(reset),
    .d_i    (1'b0),
    .q_o    (reset_sync)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    out_d   = out_q;
    done_d  = done_q;

    if (softReset) begin
      state_d = ASSERT;
      cnt_d   = '0;
      idx_d   = '0;
      out_d   = '1;
      done_d  = 1'b0;
    end else begin
      case (state_q)
        ASSERT: begin
          cnt_d  = '0;
          idx_d  = '0;
          out_d  = '1;
          done_d = 1'b0;
          if (!reset_sync) state_d = STRETCH;
        end
        STRETCH: begin
          if (!hold_active) begin
            if (cnt_q == CounterWidth'(StretchCycles - 1)) begin
              out_d[0] = 1'b0;
              cnt_d    = '0;
              if (NumOutputs == 1) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                state_d = RELEASE;
                idx_d   = IdxWidth'(1);
              end
            end else begin
              cnt_d = cnt_q + CounterWidth'(1);
            end
          end
        end
        RELEASE: begin
          if (!hold_active) begin
            if (cnt_q == CounterWidth'(StepCycles - 1)) begin
              for (int i = 0; i < int'(NumOutputs); i++) begin
                if (idx_q == IdxWidth'(i)) out_d[i] = 1'b0;
              end
              cnt_d = '0;
              if (idx_q == IdxWidth'(NumOutputs - 1)) begin
                state_d = DONE;
                done_d  = 1'b1;
              end else begin
                idx_d = idx_q + IdxWidth'(1);
              end
            end else begin
              cnt_d = cnt_q + CounterWidth'(1);
            end
          end
        end
        DONE: begin
        end
        default: begin
          state_d = ASSERT;
        end
      endcase
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ASSERT;
      cnt_q   <= '0;
      idx_q   <= '0;
      out_q   <= '1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      out_q   <= out_d;
      done_q  <= done_d;
    end
  end

  for (genvar g = 0; g < int'(NumOutputs); g++) begin : g_out_pipe
    oclib_reset_pipe #(
      .Length    (ResetPipeline),
      .ResetValue(1'b1)
    ) u_out_pipe (
      .clock_i(clock),
      .reset_i(reset),
      .d_i    (out_q[g]),
      .q_o    (out[g])
    );
  end

  oclib_reset_pipe #(
    .Length    (ResetPipeline),
    .ResetValue(1'b0)
  ) u_done_pipe (
    .clock_i(clock),
    .reset_i(reset),
    .d_i    (done_q),
    .q_o    (done)
  );

endmodule

// File: tb/tb_oclib_reset_sequencer.sv
// Bench for oclib_reset_sequencer: default instance plus a piped single-output instance,
// both checked every cycle against an edge-schedule model.
module tb_oclib_reset_sequencer;

  localparam int N   = 4;
  localparam int S   = 3;
  localparam int ST  = 16;
  localparam int SP  = 8;
  localparam int BIG = 1 << 28;
`ifdef OCLIB_RESET_SEQUENCER_HOLD_EN
  localparam bit HoldEn = 1'b1;
`else
  localparam bit HoldEn = 1'b0;
`endif

  logic         clock = 1'b0;
  logic         reset = 1'b0;
  logic         soft_reset = 1'b0;
  logic         hold = 1'b0;
  logic [N-1:0] out;
  logic         done;
  logic [0:0]   p_out;
  logic         p_done;

  // Model: absolute edge numbers at which each output falls.
  int edge_n = 0;
  int sync_fall = BIG;
  int origin = BIG;
  int fall[N];
  int p_fall = BIG;
  bit in_reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clock = ~clock;

  oclib_reset_sequencer u_dut (
    .clock    (clock),
    .reset    (reset),
    .softReset(soft_reset),
`ifdef OCLIB_RESET_SEQUENCER_HOLD_EN
    .hold     (hold),
`endif
    .out      (out),
    .done     (done)
  );

  oclib_reset_sequencer #(
    .NumOutputs   (1),
    .StretchCycles(1),
    .ResetPipeline(2)
  ) u_dut_pipe (
    .clock    (clock),
    .reset    (reset),
    .softReset(1'b0),
`ifdef OCLIB_RESET_SEQUENCER_HOLD_EN
    .hold     (1'b0),
`endif
    .out      (p_out),
    .done     (p_done)
  );

  function automatic void recompute();
    for (int i = 0; i < N; i++) fall[i] = origin + ST + i * SP;
  endfunction

  function automatic void model_edge();
    if (!in_reset) begin
      if (soft_reset) begin
        origin = ((edge_n > sync_fall) ? edge_n : sync_fall) + 1;
        recompute();
      end else if (hold && origin < edge_n && edge_n <= fall[N-1]) begin
        for (int i = 0; i < N; i++) if (fall[i] >= edge_n) fall[i]++;
      end
    end
  endfunction

  task automatic check();
    logic [N-1:0] exp_out;
    logic         exp_done;
    logic [0:0]   exp_p_out;
    logic         exp_p_done;
    for (int i = 0; i < N; i++) exp_out[i] = in_reset || (edge_n < fall[i]);
    exp_done      = !in_reset && (edge_n >= fall[N-1]);
    exp_p_out[0]  = in_reset || (edge_n < p_fall);
    exp_p_done    = !in_reset && (edge_n >= p_fall);
    vectors += 4;
    assert (out === exp_out) else begin
      miscompares++;
      $error("FAIL out: observed %h expected %h at edge %0d", out, exp_out, edge_n);
    end
    assert (done === exp_done) else begin
      miscompares++;
      $error("FAIL done: observed %b expected %b at edge %0d", done, exp_done, edge_n);
    end
    assert (p_out === exp_p_out) else begin
      miscompares++;
      $error("FAIL pipe_out: observed %b expected %b at edge %0d", p_out, exp_p_out, edge_n);
    end
    assert (p_done === exp_p_done) else begin
      miscompares++;
      $error("FAIL pipe_done: observed %b expected %b at edge %0d", p_done, exp_p_done, edge_n);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    edge_n++;
    model_edge();
    #1;
    check();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Asynchronous assertion between edges; outputs must respond with no clock.
  task automatic reset_assert();
    #1;
    reset    = 1'b1;
    in_reset = 1'b1;
    sync_fall = BIG;
    origin   = BIG;
    recompute();
    p_fall   = BIG;
    #1;
    check();
  endtask

  task automatic reset_release();
    #1;
    reset     = 1'b0;
    in_reset  = 1'b0;
    sync_fall = edge_n + S;
    origin    = sync_fall + 1;
    recompute();
    p_fall    = sync_fall + 1 + 1 + 2;
  endtask

  initial begin
    int target;
    int r;
    recompute();

    // Reset state before any clock edge.
    #1 reset = 1'b1;
    #1 check();

    // Power-on sequence: reset held 10 cycles.
    ticks(10);
    reset_release();
    ticks(50);

    // softReset pulse in DONE restarts the sequence.
    ticks($urandom_range(1, 5));
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;

    // Async reset mid-RELEASE, after out[1] has fallen.
    target = fall[1] + $urandom_range(1, 4);
    for (int g = 0; g < 200 && edge_n < target; g++) tick();
    reset_assert();
    ticks($urandom_range(2, 6));
    reset_release();
    ticks(55);

`ifdef OCLIB_RESET_SEQUENCER_HOLD_EN
    soft_reset = 1'b1;
    tick();
    soft_reset = 1'b0;
    ticks(3);
    hold = 1'b1;
    ticks(5);
    hold = 1'b0;
    ticks(55);
    hold = 1'b1;
    tick();
    hold = 1'b0;
    ticks(5);
`endif

    // reset and softReset together; reset released while softReset stays high.
    reset_assert();
    soft_reset = 1'b1;
    ticks(3);
    reset_release();
    ticks(20);
    soft_reset = 1'b0;
    ticks(55);

    // Random mix of soft resets, holds and async resets.
    for (int c = 0; c < 600; c++) begin
      r = $urandom_range(0, 199);
      if (r < 2) begin
        reset_assert();
        ticks($urandom_range(1, 4));
        reset_release();
      end else begin
        soft_reset = (r < 6);
        hold       = HoldEn && (r >= 6) && (r < 40);
        tick();
        soft_reset = 1'b0;
        hold       = 1'b0;
      end
    end
    ticks(60);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
